// File: rtl/vga_text_writer_if.sv
// Requester-side command bus for vga_text_writer.
// One lane per requester. Each lane carries a valid bit, a 2-bit opcode,
// a 24-bit operand and a ready bit that comes back from the writer.
//   Req_Valid  [N_REQ]     command valid per requester
//   Req_Ready  [N_REQ]     accept per requester (driven by the writer)
//   Req_Cmd    [2*N_REQ]   opcode per requester: 0 PUT, 1 CURSOR, 2 COLOUR, 3 CLEAR
//   Req_Data   [24*N_REQ]  operand per requester
interface vga_text_writer_if #(
  parameter int N_REQ = 2
);
  logic [N_REQ-1:0]    Req_Valid;
  logic [N_REQ-1:0]    Req_Ready;
  logic [2*N_REQ-1:0]  Req_Cmd;
  logic [24*N_REQ-1:0] Req_Data;

  modport master (output Req_Valid, output Req_Cmd, output Req_Data, input Req_Ready);
  modport slave  (input Req_Valid, input Req_Cmd, input Req_Data, output Req_Ready);
endinterface

// File: rtl/vga_text_writer.sv
// vga_text_writer: command-driven front end for the text display write port.
// N_REQ requesters share one write port through round-robin arbitration.
// Each requester owns a cursor and a foreground/background colour context.
// PUT writes one glyph at the cursor and advances it. CURSOR moves the cursor.
// COLOUR sets the colours. CLEAR fills the whole screen with CLEAR_GLYPH.
//
// Ports:
//   Clk, nReset      clock, asynchronous active-low reset
//   req              requester bus (vga_text_writer_if.slave)
//   Line, Character  display write position (line, column)
//   Glyph            display write glyph
//   Foreground       display write foreground colour (RGB 4:4:4)
//   Background       display write background colour (RGB 4:4:4)
//   Latch            display write strobe, one cycle per character
//   Busy             high while clear-screen runs
//
// Optional build macro VGA_TEXT_CTRL_CHARS_EN: when defined, PUT treats
// 8'h0A (newline), 8'h0D (carriage return) and 8'h08 (backspace) as cursor
// moves instead of writes.
module vga_text_writer #(
  parameter int          N_REQ       = 2,
  parameter int          COLS        = 80,
  parameter int          ROWS        = 30,
  parameter logic [7:0]  CLEAR_GLYPH = 8'h20,
  parameter logic [11:0] DEF_FG      = 12'hFFF,
  parameter logic [11:0] DEF_BG      = 12'h000
) (
  input  logic            Clk,
  input  logic            nReset,
  vga_text_writer_if.slave req,
  output logic [4:0]      Line,
  output logic [6:0]      Character,
  output logic [7:0]      Glyph,
  output logic [11:0]     Foreground,
  output logic [11:0]     Background,
  output logic            Latch,
  output logic            Busy
);

  localparam int         PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [4:0] LAST_LINE = 5'(ROWS - 1);
  localparam logic [6:0] LAST_COL  = 7'(COLS - 1);

  localparam logic [1:0] CMD_PUT    = 2'd0;
  localparam logic [1:0] CMD_CURSOR = 2'd1;
  localparam logic [1:0] CMD_COLOUR = 2'd2;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [PTR_W-1:0] clr_owner;
  logic             gnt_found;
  int               scan_idx;

  logic [1:0]       sel_cmd;
  logic [23:0]      sel_data;
  logic [4:0]       gnt_line;
  logic [6:0]       gnt_col;
  logic [11:0]      gnt_fg, gnt_bg;

  logic [4:0]       ctx_line [N_REQ];
  logic [6:0]       ctx_col  [N_REQ];
  logic [11:0]      ctx_fg   [N_REQ];
  logic [11:0]      ctx_bg   [N_REQ];

  logic             fire;
  logic             put_wr, cur_wr, colour_wr, clr_start, clr_done;
  logic [4:0]       new_line;
  logic [6:0]       new_col;

  // Next position in row-major scan order, wrapping from the last cell to (0,0).
  function automatic logic [11:0] advance(input logic [4:0] line, input logic [6:0] col);
    if (col == LAST_COL)
      return {(line == LAST_LINE) ? 5'd0 : line + 5'd1, 7'd0};
    return {line, col + 7'd1};
  endfunction

  // Round-robin search starting at rr_ptr.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < N_REQ; k++) begin
      scan_idx = (int'(rr_ptr) + k) % N_REQ;
      if (!gnt_found && req.Req_Valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(scan_idx);
      end
    end
  end

  // Command and context of the granted requester.
  always_comb begin
    sel_cmd  = '0;
    sel_data = '0;
    gnt_line = '0;
    gnt_col  = '0;
    gnt_fg   = '0;
    gnt_bg   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == PTR_W'(i)) begin
        sel_cmd  = req.Req_Cmd[2*i +: 2];
        sel_data = req.Req_Data[24*i +: 24];
        gnt_line = ctx_line[i];
        gnt_col  = ctx_col[i];
        gnt_fg   = ctx_fg[i];
        gnt_bg   = ctx_bg[i];
      end
    end
  end

  always_comb begin
    req.Req_Ready = '0;
    for (int i = 0; i < N_REQ; i++)
      if ((state == IDLE) && gnt_found && (gnt_idx == PTR_W'(i)))
        req.Req_Ready[i] = 1'b1;
  end

  assign fire = (state == IDLE) && gnt_found;
  assign Busy = (state == CLEAR);

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    put_wr    = 1'b0;
    cur_wr    = 1'b0;
    colour_wr = 1'b0;
    clr_start = 1'b0;
    clr_done  = 1'b0;
    new_line  = gnt_line;
    new_col   = gnt_col;
    case (state)
      IDLE: begin
        if (fire) begin
          case (sel_cmd)
            CMD_PUT: begin
`ifdef VGA_TEXT_CTRL_CHARS_EN
              cur_wr = 1'b1;
              case (sel_data[7:0])
                8'h0A: begin
                  new_col  = 7'd0;
                  new_line = (gnt_line == LAST_LINE) ? 5'd0 : gnt_line + 5'd1;
                end
                8'h0D: new_col = 7'd0;
                8'h08: begin
                  if (gnt_col != 7'd0) begin
                    new_col = gnt_col - 7'd1;
                  end else if (gnt_line != 5'd0) begin
                    new_line = gnt_line - 5'd1;
                    new_col  = LAST_COL;
                  end
                end
                default: begin
                  put_wr              = 1'b1;
                  {new_line, new_col} = advance(gnt_line, gnt_col);
                end
              endcase
`else
              put_wr              = 1'b1;
              cur_wr              = 1'b1;
              {new_line, new_col} = advance(gnt_line, gnt_col);
`endif
            end
            CMD_CURSOR: begin
              // Out-of-range targets are accepted but ignored.
              if ((sel_data[6:0] <= LAST_COL) && (sel_data[12:8] <= LAST_LINE)) begin
                cur_wr   = 1'b1;
                new_col  = sel_data[6:0];
                new_line = sel_data[12:8];
              end
            end
            CMD_COLOUR: colour_wr = 1'b1;
            default: begin
              clr_start = 1'b1;
              state_nxt = CLEAR;
            end
          endcase
        end
      end
      CLEAR: begin
        // Line/Character hold the cell currently on the port; the scan ends
        // once the last cell has been presented.
        if ((Line == LAST_LINE) && (Character == LAST_COL)) begin
          clr_done  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Display write port registers.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      Latch      <= 1'b0;
      Line       <= '0;
      Character  <= '0;
      Glyph      <= '0;
      Foreground <= '0;
      Background <= '0;
      clr_owner  <= '0;
    end else if (clr_start) begin
      Latch      <= 1'b1;
      Line       <= '0;
      Character  <= '0;
      Glyph      <= CLEAR_GLYPH;
      Foreground <= gnt_fg;
      Background <= gnt_bg;
      clr_owner  <= gnt_idx;
    end else if (state == CLEAR) begin
      if (clr_done) begin
        Latch <= 1'b0;
      end else begin
        Latch               <= 1'b1;
        {Line, Character}   <= advance(Line, Character);
      end
    end else if (put_wr) begin
      Latch      <= 1'b1;
      Line       <= gnt_line;
      Character  <= gnt_col;
      Glyph      <= sel_data[7:0];
      Foreground <= gnt_fg;
      Background <= gnt_bg;
    end else begin
      Latch <= 1'b0;
    end
  end

  // Per-requester contexts; only the granted (or clearing) requester changes.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < N_REQ; i++) begin
        ctx_line[i] <= '0;
        ctx_col[i]  <= '0;
        ctx_fg[i]   <= DEF_FG;
        ctx_bg[i]   <= DEF_BG;
      end
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (fire && (gnt_idx == PTR_W'(i))) begin
          if (cur_wr) begin
            ctx_line[i] <= new_line;
            ctx_col[i]  <= new_col;
          end
          if (colour_wr) begin
            ctx_fg[i] <= sel_data[11:0];
            ctx_bg[i] <= sel_data[23:12];
          end
        end
        if (clr_done && (clr_owner == PTR_W'(i))) begin
          ctx_line[i] <= '0;
          ctx_col[i]  <= '0;
        end
      end
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset)   rr_ptr <= '0;
    else if (fire) rr_ptr <= PTR_W'((int'(gnt_idx) + 1) % N_REQ);
  end

endmodule

// File: tb/tb_vga_text_writer.sv
// Testbench for vga_text_writer: directed scenarios followed by randomized
// traffic, all checked against a behavioural model of the text writer that
// tracks each requester's cursor as a linear cell index.
module tb_vga_text_writer;

  localparam int N    = 2;
  localparam int COLS = 80;
  localparam int ROWS = 30;
  localparam int CELLS = COLS * ROWS;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  Line;
  logic [6:0]  Character;
  logic [7:0]  Glyph;
  logic [11:0] Foreground, Background;
  logic        Latch, Busy;

  vga_text_writer_if #(.N_REQ(N)) bus ();

  vga_text_writer #(.N_REQ(N), .COLS(COLS), .ROWS(ROWS)) dut (
    .Clk        (clk),
    .nReset     (rst_n),
    .req        (bus),
    .Line       (Line),
    .Character  (Character),
    .Glyph      (Glyph),
    .Foreground (Foreground),
    .Background (Background),
    .Latch      (Latch),
    .Busy       (Busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int          m_pos [N];
  logic [11:0] m_fg  [N];
  logic [11:0] m_bg  [N];
  int          m_rr;
  int          m_clr_k;    // cell currently shown by an active clear, -1 when idle
  int          m_clr_own;
  logic        e_latch, e_busy;
  logic [4:0]  e_line;
  logic [6:0]  e_col;
  logic [7:0]  e_glyph;
  logic [11:0] e_fg, e_bg;
  logic [1:0]  exp_ready;

  logic        obs_latch, obs_busy;
  logic [4:0]  obs_line;
  logic [6:0]  obs_col;

  task automatic model_reset();
    for (int r = 0; r < N; r++) begin
      m_pos[r] = 0;
      m_fg[r]  = 12'hFFF;
      m_bg[r]  = 12'h000;
    end
    m_rr = 0; m_clr_k = -1; m_clr_own = 0;
    e_latch = 0; e_busy = 0; e_line = 0; e_col = 0; e_glyph = 0; e_fg = 0; e_bg = 0;
    exp_ready = 0;
  endtask

  task automatic show_write(input int pos, input logic [7:0] g, input logic [11:0] fg, input logic [11:0] bg);
    e_latch = 1'b1;
    e_line  = 5'(pos / COLS);
    e_col   = 7'(pos % COLS);
    e_glyph = g;
    e_fg    = fg;
    e_bg    = bg;
  endtask

  task automatic model_step(input logic [1:0] v, input logic [3:0] c, input logic [47:0] d);
    int g;
    logic [1:0]  op;
    logic [23:0] od;
    e_latch   = 1'b0;
    exp_ready = 2'b00;
    if (m_clr_k >= 0) begin
      if (m_clr_k == CELLS - 1) begin
        m_clr_k = -1;
        m_pos[m_clr_own] = 0;
        e_busy = 1'b0;
      end else begin
        m_clr_k++;
        show_write(m_clr_k, 8'h20, e_fg, e_bg);
      end
    end else begin
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && v[(m_rr + k) % N]) g = (m_rr + k) % N;
      if (g >= 0) begin
        exp_ready[g] = 1'b1;
        m_rr = (g + 1) % N;
        op = c[2*g +: 2];
        od = d[24*g +: 24];
        case (op)
          2'd0: begin
`ifdef VGA_TEXT_CTRL_CHARS_EN
            if (od[7:0] == 8'h0A)      m_pos[g] = ((m_pos[g] / COLS + 1) % ROWS) * COLS;
            else if (od[7:0] == 8'h0D) m_pos[g] = (m_pos[g] / COLS) * COLS;
            else if (od[7:0] == 8'h08) m_pos[g] = (m_pos[g] > 0) ? m_pos[g] - 1 : 0;
            else begin
              show_write(m_pos[g], od[7:0], m_fg[g], m_bg[g]);
              m_pos[g] = (m_pos[g] + 1) % CELLS;
            end
`else
            show_write(m_pos[g], od[7:0], m_fg[g], m_bg[g]);
            m_pos[g] = (m_pos[g] + 1) % CELLS;
`endif
          end
          2'd1: if (od[6:0] < COLS && od[12:8] < ROWS) m_pos[g] = int'(od[12:8]) * COLS + int'(od[6:0]);
          2'd2: begin
            m_fg[g] = od[11:0];
            m_bg[g] = od[23:12];
          end
          default: begin
            m_clr_k = 0;
            m_clr_own = g;
            e_busy = 1'b1;
            show_write(0, 8'h20, m_fg[g], m_bg[g]);
          end
        endcase
      end
    end
  endtask

  function automatic logic [63:0] dut_vec();
    return {18'd0, Latch, Busy, Line, Character, Glyph, Foreground, Background};
  endfunction

  function automatic logic [63:0] exp_vec();
    return {18'd0, e_latch, e_busy, e_line, e_col, e_glyph, e_fg, e_bg};
  endfunction

  // One clock of traffic: check last edge's outputs, drive new inputs, predict.
  task automatic cycle(input logic [1:0] v, input logic [3:0] c, input logic [47:0] d);
    @(negedge clk);
    chk("out", dut_vec(), exp_vec());
    obs_latch = Latch; obs_busy = Busy; obs_line = Line; obs_col = Character;
    bus.Req_Valid = v; bus.Req_Cmd = c; bus.Req_Data = d;
    #1;
    model_step(v, c, d);
    chk("ready", {62'd0, bus.Req_Ready}, {62'd0, exp_ready});
  endtask

  task automatic peek();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_write(input string tag, input int line, input int col, input logic [7:0] gl,
                              input logic [11:0] fg, input logic [11:0] bg);
    chk(tag, {19'd0, Latch, Line, Character, Glyph, Foreground, Background},
        {19'd0, 1'b1, 5'(line), 7'(col), gl, fg, bg});
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.Req_Valid = '0; bus.Req_Cmd = '0; bus.Req_Data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", dut_vec(), 64'd0);
    chk("rst_ready", {62'd0, bus.Req_Ready}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n, gaps, clears_left;
    logic [11:0] last;
    logic [1:0]  v;
    logic [3:0]  c;
    logic [47:0] d;
    int x;

    apply_reset();

    // Basic PUT and auto-advance.
    cycle(2'b01, 4'b0000, {24'd0, 24'h41});
    peek(); expect_write("put_first", 0, 0, 8'h41, 12'hFFF, 12'h000);
    cycle(2'b01, 4'b0000, {24'd0, 24'h61});
    peek(); expect_write("put_next", 0, 1, 8'h61, 12'hFFF, 12'h000);

    // Cursor to the last cell, wrap-around, out-of-range cursor ignored.
    cycle(2'b01, 4'b0001, {24'd0, 24'(29 * 256 + 79)});
    cycle(2'b01, 4'b0000, {24'd0, 24'h42});
    peek(); expect_write("put_last_cell", 29, 79, 8'h42, 12'hFFF, 12'h000);
    cycle(2'b01, 4'b0000, {24'd0, 24'h42});
    peek(); expect_write("put_wrap", 0, 0, 8'h42, 12'hFFF, 12'h000);
    cycle(2'b01, 4'b0001, {24'd0, 24'(3 * 256 + 80)});
    cycle(2'b01, 4'b0000, {24'd0, 24'h43});
    peek(); expect_write("cursor_bad", 0, 1, 8'h43, 12'hFFF, 12'h000);

    // req1 colours, then both requesters streaming PUTs.
    cycle(2'b10, {2'd2, 2'd0}, {24'h00F0F0, 24'd0});
    for (int k = 0; k < 6; k++) begin
      cycle(2'b11, 4'b0000, {24'h44, 24'h45});
      chk("alt_grant", {62'd0, bus.Req_Ready}, (k % 2 == 0) ? 64'd1 : 64'd2);
      peek();
      if (k % 2 == 0) expect_write("alt_req0", 0, 2 + k / 2, 8'h45, 12'hFFF, 12'h000);
      else            expect_write("alt_req1", 0, k / 2, 8'h44, 12'h0F0, 12'h00F);
    end

    // Clear by req1 with req0 waiting.
    cycle(2'b10, {2'd3, 2'd0}, 48'd0);
    n = 0; gaps = 0; last = '0;
    for (int t = 0; t < 2500; t++) begin
      cycle(2'b01, 4'b0000, {24'd0, 24'h5A});
      if (!obs_busy) break;
      if (obs_latch) begin
        n++;
        last = {obs_line, obs_col};
      end else begin
        gaps++;
      end
    end
    chk("clr_count", 64'(n), 64'd2400);
    chk("clr_gaps", 64'(gaps), 64'd0);
    chk("clr_last", {52'd0, last}, {52'd0, 5'd29, 7'd79});
    chk("clr_then_grant", {62'd0, bus.Req_Ready}, 64'd1);

    // Reset in the middle of a clear.
    cycle(2'b01, {2'd0, 2'd3}, 48'd0);
    n = 0;
    for (int t = 0; t < 1100 && n < 1001; t++) begin
      cycle(2'b00, 4'b0000, 48'd0);
      if (obs_latch) n++;
    end
    chk("clr_reached_1000", 64'(n), 64'd1001);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_now", dut_vec(), 64'd0);
    apply_reset();
    cycle(2'b10, 4'b0000, {24'h47, 24'd0});
    peek(); expect_write("post_rst_put", 0, 0, 8'h47, 12'hFFF, 12'h000);

    // Control glyph handling.
    cycle(2'b01, 4'b0000, {24'd0, 24'h41});
    peek(); expect_write("ctl_a", 0, 0, 8'h41, 12'hFFF, 12'h000);
    cycle(2'b01, 4'b0000, {24'd0, 24'h0A});
    peek();
`ifdef VGA_TEXT_CTRL_CHARS_EN
    chk("ctl_nl_nolatch", {63'd0, Latch}, 64'd0);
`else
    expect_write("ctl_nl_literal", 0, 1, 8'h0A, 12'hFFF, 12'h000);
`endif
    cycle(2'b01, 4'b0000, {24'd0, 24'h42});
    peek();
`ifdef VGA_TEXT_CTRL_CHARS_EN
    expect_write("ctl_b", 1, 0, 8'h42, 12'hFFF, 12'h000);
`else
    expect_write("ctl_b", 0, 2, 8'h42, 12'hFFF, 12'h000);
`endif

    // Randomized traffic.
    clears_left = 2;
    for (int t = 0; t < 8000; t++) begin
      v = '0; c = '0; d = '0;
      for (int r = 0; r < N; r++) begin
        v[r] = ($urandom_range(0, 3) != 0);
        x = $urandom_range(0, 99);
        if (x < 60 || (x >= 97 && clears_left == 0)) begin
          c[2*r +: 2] = 2'd0;
          if ($urandom_range(0, 7) == 0) begin
            case ($urandom_range(0, 2))
              0: d[24*r +: 24] = 24'h0A;
              1: d[24*r +: 24] = 24'h0D;
              default: d[24*r +: 24] = 24'h08;
            endcase
          end else begin
            d[24*r +: 24] = 24'($urandom_range(0, 255));
          end
        end else if (x < 80) begin
          c[2*r +: 2] = 2'd1;
          d[24*r +: 24] = 24'($urandom_range(0, 33) * 256 + $urandom_range(0, 90));
        end else if (x < 97) begin
          c[2*r +: 2] = 2'd2;
          d[24*r +: 24] = 24'($urandom);
        end else begin
          c[2*r +: 2] = 2'd3;
          clears_left--;
        end
      end
      cycle(v, c, d);
    end
    cycle(2'b00, 4'b0000, 48'd0);
    cycle(2'b00, 4'b0000, 48'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_text_writer.md
Name: vga_text_writer

Overview:
- Command-driven front end for the VGA text display's write port (Line/Character/Glyph/Foreground/Background/Latch), clocked on the interface clock.
- Shares that single write port between N_REQ requesters with round-robin arbitration.
- Keeps a private cursor and colour context per requester, auto-advances the cursor and runs a hardware clear-screen sequence.
- Sits between system-side producers (status printers, debug consoles) and the text display block.

Parameters:
N_REQ, 2, number of requesters (1..4)
COLS, 80, text columns per line
ROWS, 30, text lines per screen
CLEAR_GLYPH, 8'h20, glyph written by clear-screen
DEF_FG, 12'hFFF, reset foreground colour (RGB 4:4:4)
DEF_BG, 12'h000, reset background colour

Ports:
Clk  in  1  interface clock
nReset  in  1  asynchronous active-low reset
Req_Valid  in  N_REQ  per-requester command valid
Req_Ready  out  N_REQ  per-requester accept, combinational
Req_Cmd  in  2*N_REQ  per-requester opcode: 0 PUT, 1 CURSOR, 2 COLOUR, 3 CLEAR
Req_Data  in  24*N_REQ  per-requester operand
Line  out  5  display write line
Character  out  7  display write column
Glyph  out  8  display write glyph
Foreground  out  12  display write foreground
Background  out  12  display write background
Latch  out  1  display write strobe, one cycle per character
Busy  out  1  high while clear-screen runs

Behaviour:
- Clock and reset: one clock (Clk); reset nReset is asynchronous, active-low.
- Reset state: all outputs 0, Latch 0, Busy 0, FSM IDLE, RR pointer 0; every context set to cursor (0,0), FG DEF_FG, BG DEF_BG.
- FSM states: IDLE, CLEAR.
- Arbitration in IDLE:
  - Grant the first i with Req_Valid[i], searching from the RR pointer upward (mod N_REQ).
  - Req_Ready[i] = IDLE && grant==i. At most one Ready is high at a time.
  - Transfer on Valid&Ready. Pointer <= i+1 mod N_REQ.
  - In CLEAR, all Ready are 0.
- PUT (Data[7:0] glyph):
  - Next cycle: Latch=1, Line/Character = requester's cursor, Glyph = Data[7:0], FG/BG = requester's colours.
  - Cursor then advances: Character+1. At COLS-1, Character wraps to 0 and Line+1. At Line ROWS-1 with Character COLS-1, cursor wraps to (0,0).
- CURSOR (Data[6:0] column, Data[12:8] line):
  - If column<COLS and line<ROWS, the cursor is updated.
  - Otherwise the command is accepted and the cursor is unchanged.
  - No Latch.
- COLOUR (Data[11:0] FG, Data[23:12] BG): updates the context; no Latch.
- CLEAR:
  - Enter CLEAR; Busy=1 from the next cycle.
  - Latch high for ROWS*COLS consecutive cycles, scanning (0,0),(0,1)..(ROWS-1,COLS-1) row-major.
  - Writes use Glyph=CLEAR_GLYPH and the issuing requester's colours.
  - After the last write: IDLE, Busy=0, issuer cursor set to (0,0). Other contexts untouched.
- Throughput: one PUT/CURSOR/COLOUR per cycle, back-to-back. Latch is deasserted in any cycle without a write.
- Only the granted requester's context changes in a given cycle.
- nReset asserted mid-CLEAR: Latch drops immediately (asynchronously). No further writes; contexts return to defaults.
- Output registers hold their last values when Latch=0, except after reset.

Optional Feature:
VGA_TEXT_CTRL_CHARS_EN
- Defined, PUT interprets control glyphs:
  - 8'h0A: cursor to column 0 of next line (ROWS-1 wraps to 0), no Latch.
  - 8'h0D: column 0, same line, no Latch.
  - 8'h08: cursor back one position (from (0,0) stays at (0,0)), no Latch.
- Undefined, all glyph values are written literally as ordinary PUT.

Test Plan:
- Reset, then req0 PUT 8'h41 -> one cycle later Latch=1, Line=0, Character=0, Glyph=8'h41, FG=12'hFFF, BG=12'h000; a following PUT lands at Character=1.
- req0 CURSOR to line 29 col 79, then PUT 8'h42 twice -> writes at (29,79) then (0,0); CURSOR col 80 line 3 -> cursor unchanged.
- req0 and req1 hold Valid with PUT every cycle -> grants alternate 0,1,0,1. req1 COLOUR FG 12'h0F0, BG 12'h00F -> req1 writes carry the new colours, req0 writes still carry 12'hFFF/12'h000.
- req1 CLEAR -> Busy high, exactly 2400 consecutive Latch pulses, Glyph 8'h20, last write at (29,79). req0 Ready stays 0 throughout and its pending PUT is granted on the cycle after the last write.
- Drop nReset at clear write 1000 -> Latch 0 immediately, all outputs 0; after release, PUT writes at (0,0) with default colours.
- With VGA_TEXT_CTRL_CHARS_EN: PUT 'A', 8'h0A, 'B' -> two Latches at (0,0) and (1,0). Without the macro: three Latches at (0,0),(0,1),(0,2), the middle one with Glyph 8'h0A.
